// File: rtl/lif_core_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : lif_core_scheduler
//  Description : Time-multiplexed leaky-integrate-and-fire controller. One
//                update datapath is shared by N_NEURONS virtual neurons; a
//                timestep walks every neuron once, one per cycle, and hands
//                spikes to the downstream router over a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_core_scheduler #(
    parameter int N_NEURONS = 8,
    parameter int PW        = 4,
    parameter int THRESHOLD = 8,
    parameter int LEAK      = 1,
    localparam int IDW      = $clog2(N_NEURONS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_we,
    input  logic [IDW-1:0] in_addr,
    input  logic [PW-1:0]  in_data,
    input  logic           step_start,
    output logic           step_busy,
    output logic           step_done,
    output logic           spike_valid,
    input  logic           spike_ready,
    output logic [IDW-1:0] spike_id,
    input  logic [IDW-1:0] rd_addr,
    output logic [PW-1:0]  rd_data
);

    // Sum and threshold share a PW+1 bit space so pot+cur never wraps.
    localparam logic [PW:0]    c_THRESH = (PW+1)'(THRESHOLD);
    localparam logic [PW:0]    c_LEAK   = (PW+1)'(LEAK);
    localparam logic [IDW-1:0] c_LAST   = IDW'(N_NEURONS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]     r_state;
    logic [IDW-1:0] r_idx;
    logic [PW-1:0]  r_pot [N_NEURONS];
    logic [PW-1:0]  r_cur [N_NEURONS];
    logic           r_step_busy;
    logic           r_step_done;
    logic           r_spike_valid;
    logic [IDW-1:0] r_spike_id;
    logic [PW-1:0]  r_rd_data;

    logic [PW:0]    w_sum;
    logic           w_fire;
    logic [PW-1:0]  w_leaked;

    // Leak/integrate/fire arithmetic for the neuron currently selected by r_idx.
    always_comb begin
        w_sum    = {1'b0, r_pot[r_idx]} + {1'b0, r_cur[r_idx]};
        w_fire   = (w_sum >= c_THRESH);
        w_leaked = '0;
        if (w_sum > c_LEAK) begin
            // Non-firing sums are below THRESHOLD, so they fit in PW bits.
            w_leaked = PW'(w_sum - c_LEAK);
        end
    end

    // Timestep sequencer: owns neuron state, the spike stream and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_step_busy   <= 1'b0;
            r_step_done   <= 1'b0;
            r_spike_valid <= 1'b0;
            r_spike_id    <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_pot[i] <= '0;
                r_cur[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Writes are only accepted here; a same-cycle start sees the new value.
                    if (in_we) begin
                        r_cur[in_addr] <= in_data;
                    end
                    if (step_start) begin
                        r_idx       <= '0;
                        r_step_busy <= 1'b1;
                        r_state     <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_cur[r_idx] <= '0;
                    if (w_fire) begin
                        r_pot[r_idx]  <= '0;
                        r_spike_valid <= 1'b1;
                        r_spike_id    <= r_idx;
                        r_state       <= S_EMIT;
                    end else begin
                        r_pot[r_idx] <= w_leaked;
                        if (r_idx == c_LAST) begin
                            r_step_done <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_idx <= r_idx + IDW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    // Hold the event until the router takes it; the walk pauses meanwhile.
                    if (r_spike_valid && spike_ready) begin
                        r_spike_valid <= 1'b0;
                        if (r_idx == c_LAST) begin
                            r_step_done <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + IDW'(1);
                            r_state <= S_UPDATE;
                        end
                    end
                end
                default: begin
                    r_step_done <= 1'b0;
                    r_step_busy <= 1'b0;
                    r_idx       <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Registered potential readback, one cycle behind rd_addr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_pot[rd_addr];
        end
    end

    assign step_busy   = r_step_busy;
    assign step_done   = r_step_done;
    assign spike_valid = r_spike_valid;
    assign spike_id    = r_spike_id;
    assign rd_data     = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_lif_core_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lif_core_scheduler
//  Description : Directed, table-driven self-checking bench for
//                lif_core_scheduler (N_NEURONS=8, PW=4, THRESHOLD=8, LEAK=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_core_scheduler;

    localparam int c_N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_we;
    logic [2:0] in_addr;
    logic [3:0] in_data;
    logic       step_start;
    logic       step_busy;
    logic       step_done;
    logic       spike_valid;
    logic       spike_ready;
    logic [2:0] spike_id;
    logic [2:0] rd_addr;
    logic [3:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc;
    int         nspk;
    logic [2:0] spk_ids [8];
    logic [3:0] v;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [3:0] data;
        logic [2:0] chk_addr;
        int         exp_nspk;
        logic [2:0] exp_id;
        logic [3:0] exp_pot;
    } vec_t;

    vec_t vecs [14];

    lif_core_scheduler #(
        .N_NEURONS (8),
        .PW        (4),
        .THRESHOLD (8),
        .LEAK      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_we       (in_we),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .step_start  (step_start),
        .step_busy   (step_busy),
        .step_done   (step_done),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spike_id    (spike_id),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic read_pot(input logic [2:0] a, output logic [3:0] val);
        rd_addr = a;
        tick();
        val = rd_data;
    endtask

    task automatic write_cur(input logic [2:0] a, input logic [3:0] d);
        in_we   = 1'b1;
        in_addr = a;
        in_data = d;
        tick();
        in_we   = 1'b0;
    endtask

    // Start a step (optionally writing in the same cycle), run it to completion
    // with the current spike_ready setting, and return to IDLE.
    task automatic run_step(input logic we, input logic [2:0] a, input logic [3:0] d);
        in_we      = we;
        in_addr    = a;
        in_data    = d;
        step_start = 1'b1;
        tick();
        in_we      = 1'b0;
        step_start = 1'b0;
        cyc  = 0;
        nspk = 0;
        while (!step_done && cyc < 200) begin
            if (spike_valid && spike_ready) begin
                if (nspk < 8) spk_ids[nspk] = spike_id;
                nspk++;
            end
            tick();
            cyc++;
        end
        check("step_done_seen", int'(step_done), 1);
        check("busy_in_done", int'(step_busy), 1);
        tick();
        check("done_one_cycle", int'(step_done), 0);
        check("busy_after_done", int'(step_busy), 0);
    endtask

    initial begin
        // {we, addr, data, chk_addr, exp_nspk, exp_id, exp_pot}
        vecs[0]  = '{1'b1, 3'd2, 4'd5,  3'd2, 0, 3'd0, 4'd4};  // 5 -> 4, no spike
        vecs[1]  = '{1'b1, 3'd0, 4'd3,  3'd0, 0, 3'd0, 4'd2};  // integrate 3 -> 2
        vecs[2]  = '{1'b1, 3'd0, 4'd3,  3'd0, 0, 3'd0, 4'd4};  // 2+3=5 -> 4
        vecs[3]  = '{1'b1, 3'd0, 4'd4,  3'd0, 1, 3'd0, 4'd0};  // 4+4=8 fires
        vecs[4]  = '{1'b1, 3'd3, 4'd5,  3'd3, 0, 3'd0, 4'd4};  // prime idx3 = 4
        vecs[5]  = '{1'b0, 3'd0, 4'd0,  3'd3, 0, 3'd0, 4'd3};  // leak
        vecs[6]  = '{1'b0, 3'd0, 4'd0,  3'd3, 0, 3'd0, 4'd2};
        vecs[7]  = '{1'b0, 3'd0, 4'd0,  3'd3, 0, 3'd0, 4'd1};
        vecs[8]  = '{1'b0, 3'd0, 4'd0,  3'd3, 0, 3'd0, 4'd0};
        vecs[9]  = '{1'b0, 3'd0, 4'd0,  3'd3, 0, 3'd0, 4'd0};  // saturate at 0
        vecs[10] = '{1'b1, 3'd4, 4'd15, 3'd4, 1, 3'd4, 4'd0};  // max current fires
        vecs[11] = '{1'b1, 3'd6, 4'd7,  3'd6, 0, 3'd0, 4'd6};  // just below threshold
        vecs[12] = '{1'b1, 3'd6, 4'd1,  3'd6, 0, 3'd0, 4'd6};  // 6+1=7 still below
        vecs[13] = '{1'b1, 3'd6, 4'd2,  3'd6, 1, 3'd6, 4'd0};  // 6+2=8 exactly fires

        rst = 1'b1; in_we = 1'b0; in_addr = '0; in_data = '0;
        step_start = 1'b0; spike_ready = 1'b1; rd_addr = '0;
        tick();
        tick();
        check("rst_busy", int'(step_busy), 0);
        check("rst_done", int'(step_done), 0);
        check("rst_valid", int'(spike_valid), 0);
        check("rst_id", int'(spike_id), 0);
        check("rst_rd", int'(rd_data), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            run_step(vecs[i].we, vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d_nspk", i), nspk, vecs[i].exp_nspk);
            check($sformatf("vec%0d_cycles", i), cyc, c_N + vecs[i].exp_nspk);
            if (vecs[i].exp_nspk == 1) check($sformatf("vec%0d_id", i), int'(spk_ids[0]), int'(vecs[i].exp_id));
            read_pot(vecs[i].chk_addr, v);
            check($sformatf("vec%0d_pot", i), int'(v), int'(vecs[i].exp_pot));
            if (i == 0) begin
                for (int a = 0; a < c_N; a++) begin
                    read_pot(3'(a), v);
                    check($sformatf("vec0_pot_all%0d", a), int'(v), (a == 2) ? 4 : 0);
                end
            end
        end

        // Two spikes in one step, emitted in ascending order.
        spike_ready = 1'b1;
        write_cur(3'd5, 4'd8);
        run_step(1'b1, 3'd7, 4'd9);
        check("strong_nspk", nspk, 2);
        check("strong_id0", int'(spk_ids[0]), 5);
        check("strong_id1", int'(spk_ids[1]), 7);
        check("strong_cycles", cyc, c_N + 2);

        // Backpressure: hold the spike for 4 cycles; idx2 must wait.
        spike_ready = 1'b0;
        rd_addr     = 3'd2;
        write_cur(3'd1, 4'd8);
        in_we = 1'b1; in_addr = 3'd2; in_data = 4'd3; step_start = 1'b1;
        tick();
        in_we = 1'b0; step_start = 1'b0;
        cyc = 0;
        while (!spike_valid && cyc < 50) begin tick(); cyc++; end
        check("bp_valid_seen", int'(spike_valid), 1);
        for (int s = 0; s < 4; s++) begin
            tick(); cyc++;
            check("bp_valid_hold", int'(spike_valid), 1);
            check("bp_id_hold", int'(spike_id), 1);
            check("bp_idx2_wait", int'(rd_data), 0);
        end
        spike_ready = 1'b1;
        while (!step_done && cyc < 200) begin tick(); cyc++; end
        check("bp_cycles", cyc, c_N + 1 + 4);
        tick();
        read_pot(3'd2, v);
        check("bp_pot2", int'(v), 2);
        read_pot(3'd1, v);
        check("bp_pot1", int'(v), 0);

        // Writes while busy are lost.
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        in_we = 1'b1; in_addr = 3'd4; in_data = 4'd15;
        tick();
        tick();
        in_we = 1'b0;
        cyc = 0;
        while (!step_done && cyc < 50) begin tick(); cyc++; end
        check("busywr_done", int'(step_done), 1);
        tick();
        run_step(1'b0, 3'd0, 4'd0);
        check("busywr_nspk", nspk, 0);
        read_pot(3'd4, v);
        check("busywr_pot4", int'(v), 0);

        // Reset while a spike is pending.
        spike_ready = 1'b0;
        write_cur(3'd0, 4'd5);
        in_we = 1'b1; in_addr = 3'd6; in_data = 4'd8; step_start = 1'b1;
        rd_addr = 3'd0;
        tick();
        in_we = 1'b0; step_start = 1'b0;
        cyc = 0;
        while (!spike_valid && cyc < 50) begin tick(); cyc++; end
        check("rstm_valid_seen", int'(spike_valid), 1);
        check("rstm_pot0_before", int'(rd_data), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstm_valid", int'(spike_valid), 0);
        check("rstm_busy", int'(step_busy), 0);
        check("rstm_rd", int'(rd_data), 0);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("rstm_no_done", int'(step_done), 0);
        end
        for (int a = 0; a < c_N; a++) begin
            read_pot(3'(a), v);
            check($sformatf("rstm_pot%0d", a), int'(v), 0);
        end
        spike_ready = 1'b1;
        run_step(1'b1, 3'd6, 4'd9);
        check("rstm_new_nspk", nspk, 1);
        check("rstm_new_id", int'(spk_ids[0]), 6);
        check("rstm_new_cycles", cyc, c_N + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
